// File: rtl/dbus_responder.sv
// Memory-side data-bus responder: word RAM answering byte-strobed writes and
// full-word reads after LATENCY cycles, with op counters and a sticky error flag.
package dbus_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module dbus_responder
  import dbus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  dbus_req_t   dreq,
  output dbus_resp_t  dresp,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic        err,
  output logic [1:0]  dbg_state_o
);
  localparam int AW = $clog2(DEPTH_WORDS);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dbus_responder: LATENCY must be within 1..15");
  end

  // Handshake: addr_ok is high only in IDLE while dreq.valid is high, and that
  // cycle's rising edge is the accept. data_ok is a single-cycle pulse exactly
  // LATENCY cycles later; dresp.data is meaningful only while data_ok is high.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [3:0]  cnt_d;
  logic [63:0] addr_q, data_q, rdata_q;
  logic [2:0]  size_q;
  logic [7:0]  strobe_q;
  logic        data_ok_q, err_q;
  logic [31:0] rd_cnt_q, wr_cnt_q;
  logic [63:0] mem [DEPTH_WORDS];

  function automatic logic bad_access(input logic [63:0] a, input logic [2:0] sz);
    logic oor, mis;
    oor = (a < BASE_ADDR) || (((a - BASE_ADDR) >> 3) >= 64'(DEPTH_WORDS));
    case (sz)
      3'd0:    mis = 1'b0;
      3'd1:    mis = a[0];
      3'd2:    mis = |a[1:0];
      default: mis = |a[2:0];
    endcase
    return oor || mis;
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [63:0] a);
    return AW'((a - BASE_ADDR) >> 3);
  endfunction

  // With LATENCY=1 the read happens on the accept edge, before the latch exists.
  logic          in_idle;
  logic [63:0]   src_addr;
  logic [2:0]    src_size;
  logic [7:0]    src_strobe;
  logic          src_read_ok;
  logic [AW-1:0] src_idx;
  logic          resp_bad;
  logic          resp_write_ok;

  always_comb begin
    in_idle       = (state_q == S_IDLE);
    src_addr      = in_idle ? dreq.addr   : addr_q;
    src_size      = in_idle ? dreq.size   : size_q;
    src_strobe    = in_idle ? dreq.strobe : strobe_q;
    src_read_ok   = (src_strobe == 8'h00) && !bad_access(src_addr, src_size);
    src_idx       = word_idx(src_addr);
    resp_bad      = bad_access(addr_q, size_q);
    resp_write_ok = (state_q == S_RESP) && (strobe_q != 8'h00) && !resp_bad;
    cnt_d         = cnt_q - 4'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      size_q    <= '0;
      strobe_q  <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
      case (state_q)
        S_IDLE: if (dreq.valid) begin
          addr_q   <= dreq.addr;
          size_q   <= dreq.size;
          strobe_q <= dreq.strobe;
          data_q   <= dreq.data;
          cnt_q    <= 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_q   <= S_RESP;
            data_ok_q <= 1'b1;
            rdata_q   <= src_read_ok ? mem[src_idx] : '0;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_d;
          if (cnt_d == 4'd0) begin
            state_q   <= S_RESP;
            data_ok_q <= 1'b1;
            rdata_q   <= src_read_ok ? mem[src_idx] : '0;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          if (strobe_q != 8'h00) wr_cnt_q <= wr_cnt_q + 32'd1;
          else                   rd_cnt_q <= rd_cnt_q + 32'd1;
          if (resp_bad) err_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Commit happens at the end of the data_ok cycle; a reset forces IDLE first.
  always_ff @(posedge clk) begin
    if (resp_write_ok) begin
      for (int i = 0; i < 8; i++) begin
        if (strobe_q[i]) mem[word_idx(addr_q)][8*i +: 8] <= data_q[8*i +: 8];
      end
    end
  end

  always_comb begin
    dresp.addr_ok = in_idle && dreq.valid;
    dresp.data_ok = data_ok_q;
    dresp.data    = rdata_q;
    rd_count      = rd_cnt_q;
    wr_count      = wr_cnt_q;
    err           = err_q;
    dbg_state_o   = state_q;
  end
endmodule

// File: tb/tb_dbus_responder.sv
// Directed bench for dbus_responder: one LATENCY=2 instance for functional
// checks, plus LATENCY=1 and LATENCY=15 instances for timing sweeps.
module tb_dbus_responder;
  import dbus_pkg::*;

  logic        clk;
  logic        reset;
  dbus_req_t   req  [3];
  dbus_resp_t  resp [3];
  logic [31:0] rdc  [3];
  logic [31:0] wrc  [3];
  logic        er   [3];
  logic [1:0]  st   [3];
  int          lat_of [3] = '{2, 1, 15};
  int          total;
  int          bad;
  logic [63:0] rd;

  dbus_responder #(.LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .dreq(req[0]), .dresp(resp[0]),
    .rd_count(rdc[0]), .wr_count(wrc[0]), .err(er[0]), .dbg_state_o(st[0]));
  dbus_responder #(.LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .dreq(req[1]), .dresp(resp[1]),
    .rd_count(rdc[1]), .wr_count(wrc[1]), .err(er[1]), .dbg_state_o(st[1]));
  dbus_responder #(.LATENCY(15)) u_l15 (
    .clk(clk), .reset(reset), .dreq(req[2]), .dresp(resp[2]),
    .rd_count(rdc[2]), .wr_count(wrc[2]), .err(er[2]), .dbg_state_o(st[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction; request fields are scrambled after the accept.
  task automatic xact(input int k, input logic [63:0] a, input logic [2:0] sz,
                      input logic [7:0] stb, input logic [63:0] d,
                      input string tag, output logic [63:0] rdata);
    int n;
    req[k] = '{valid: 1'b1, addr: a, size: sz, strobe: stb, data: d};
    #1;
    chk({tag, "_addr_ok"}, 64'(resp[k].addr_ok), 64'd1);
    tick();
    req[k] = '{valid: 1'b0, addr: ~a, size: sz, strobe: ~stb, data: ~d};
    n = 1;
    while (!resp[k].data_ok && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(lat_of[k]));
    rdata = resp[k].data;
    tick();
    chk({tag, "_ok_drop"}, 64'(resp[k].data_ok), 64'd0);
    chk({tag, "_data_idle"}, resp[k].data, 64'd0);
  endtask

  // valid held high: three reads, record accept and data_ok cycles.
  task automatic sweep(input int k);
    int acc[$];
    int dok[$];
    int l;
    l = lat_of[k];
    req[k] = '{valid: 1'b1, addr: 64'h8000_0018, size: 3'd3, strobe: 8'h00, data: 64'd0};
    for (int c = 0; c < 3 * (l + 1); c++) begin
      #1;
      if (resp[k].addr_ok) acc.push_back(c);
      if (resp[k].data_ok) dok.push_back(c);
      chk("sweep_no_overlap", 64'(resp[k].addr_ok & resp[k].data_ok), 64'd0);
      tick();
    end
    req[k].valid = 1'b0;
    chk("sweep_n_acc", 64'(acc.size()), 64'd3);
    chk("sweep_n_dok", 64'(dok.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      chk("sweep_acc_cyc", 64'(acc.size() > i ? acc[i] : -1), 64'(i * (l + 1)));
      chk("sweep_dok_cyc", 64'(dok.size() > i ? dok[i] : -1), 64'(i * (l + 1) + l));
    end
    chk("sweep_rd_count", 64'(rdc[k]), 64'd3);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) req[k] = '0;
    #12;
    chk("rst_state", 64'(st[0]), 64'd0);
    reset = 1'b1;
    tick();
    for (int c = 0; c < 20; c++) begin
      chk("rst_ok", 64'({resp[0].addr_ok, resp[0].data_ok}), 64'd0);
      chk("rst_data", resp[0].data, 64'd0);
      chk("rst_cnt", {rdc[0], wrc[0]}, 64'd0);
      chk("rst_err", 64'(er[0]), 64'd0);
      tick();
    end
    chk("rst_l1_cnt", {rdc[1], wrc[1]}, 64'd0);
    chk("rst_l15_err", 64'(er[2]), 64'd0);

    xact(0, 64'h8000_0010, 3'd3, 8'hFF, 64'h1122_3344_5566_7788, "wr1", rd);
    chk("wr1_data", rd, 64'd0);
    chk("wr1_wr_count", 64'(wrc[0]), 64'd1);
    xact(0, 64'h8000_0010, 3'd3, 8'h00, 64'd0, "rd1", rd);
    chk("rd1_data", rd, 64'h1122_3344_5566_7788);
    chk("rd1_rd_count", 64'(rdc[0]), 64'd1);

    xact(0, 64'h8000_0013, 3'd0, 8'h08, 64'h0000_0000_AB00_0000, "wrb", rd);
    xact(0, 64'h8000_0010, 3'd3, 8'h00, 64'd0, "rdb", rd);
    chk("rdb_data", rd, 64'h1122_3344_AB66_7788);
    chk("rdb_err", 64'(er[0]), 64'd0);

    xact(0, 64'h7FFF_FFF8, 3'd3, 8'h00, 64'd0, "rd_low", rd);
    chk("rd_low_data", rd, 64'd0);
    chk("rd_low_err", 64'(er[0]), 64'd1);
    xact(0, 64'h8000_0011, 3'd2, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, "wr_mis", rd);
    xact(0, 64'h8000_0010, 3'd3, 8'h00, 64'd0, "rd_after_mis", rd);
    chk("rd_after_mis_data", rd, 64'h1122_3344_AB66_7788);
    chk("wr_mis_err", 64'(er[0]), 64'd1);

    xact(0, 64'h8000_7FF8, 3'd3, 8'hFF, 64'h0000_0000_0000_CAFE, "wr_last", rd);
    xact(0, 64'h8000_7FF8, 3'd3, 8'h00, 64'd0, "rd_last", rd);
    chk("rd_last_data", rd, 64'h0000_0000_0000_CAFE);
    xact(0, 64'h8000_8000, 3'd3, 8'h00, 64'd0, "rd_high", rd);
    chk("rd_high_data", rd, 64'd0);
    xact(0, 64'h8000_8010, 3'd3, 8'hFF, 64'h5555_5555_5555_5555, "wr_high", rd);
    xact(0, 64'h8000_0010, 3'd3, 8'h00, 64'd0, "rd_noalias", rd);
    chk("rd_noalias_data", rd, 64'h1122_3344_AB66_7788);
    chk("final_wr_count", 64'(wrc[0]), 64'd5);
    chk("final_rd_count", 64'(rdc[0]), 64'd7);

    sweep(1);
    sweep(2);

    xact(0, 64'h8000_0020, 3'd3, 8'hFF, 64'h0123_4567_89AB_CDEF, "wr_old", rd);
    req[0] = '{valid: 1'b1, addr: 64'h8000_0020, size: 3'd3, strobe: 8'hFF, data: 64'h0000_0000_0000_DEAD};
    tick();
    req[0].valid = 1'b0;
    chk("mid_wait_state", 64'(st[0]), 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_state", 64'(st[0]), 64'd0);
    chk("mid_rst_cnt", {rdc[0], wrc[0]}, 64'd0);
    chk("mid_rst_err", 64'(er[0]), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    xact(0, 64'h8000_0020, 3'd3, 8'h00, 64'd0, "rd_old", rd);
    chk("rd_old_data", rd, 64'h0123_4567_89AB_CDEF);
    chk("rd_old_wr_count", 64'(wrc[0]), 64'd0);
    chk("rd_old_rd_count", 64'(rdc[0]), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dbus_responder.md
Name: dbus_responder

Overview:
- Memory-side responder for the data bus: the far end of the core's dbus_req_t/dbus_resp_t interface.
- Backs a word-organised RAM that serves byte-strobed 64-bit writes and full-word reads after a programmable latency.
- Counts completed operations and flags out-of-range or misaligned accesses.
- Replaces the ideal testbench memory in core-level simulations to exercise the core's memory_delay stall path.

Parameters:
- DEPTH_WORDS, 4096: number of 64-bit words in the array (power of two).
- BASE_ADDR, 64'h8000_0000: byte address of word 0.
- LATENCY, 2: cycles from accept to data_ok. Legal range 1..15; elaboration error outside that range.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- dreq  input  dbus_req_t  valid, addr[63:0], size[2:0] (0=1B, 1=2B, 2=4B, 3=8B), strobe[7:0], data[63:0].
- dresp  output  dbus_resp_t  addr_ok, data_ok, data[63:0].
- rd_count  output  32  completed reads.
- wr_count  output  32  completed writes.
- err  output  1  sticky: some access was out-of-range or misaligned.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; addr_ok, data_ok, dresp.data, rd_count, wr_count and err all 0.
  - RAM contents are not reset.
- States:
  - IDLE: on dreq.valid=1, assert addr_ok combinationally in this cycle and latch addr, size, strobe and data. Load cnt=LATENCY-1 and go to WAIT, or go straight to RESP if LATENCY=1.
  - WAIT: decrement cnt each cycle; at cnt=0 go to RESP. All dreq changes are ignored; the latched copy is authoritative.
  - RESP: data_ok=1 for exactly one cycle, then return to IDLE.
- Timing: data_ok is asserted exactly LATENCY cycles after the accept edge.
- In the data_ok cycle addr_ok=0 and no new accept occurs. The next request can be accepted in the following cycle.
- Back-to-back throughput: one request per LATENCY+1 cycles.
- Access classification:
  - write if the latched strobe is not 0, else read.
  - word index = (addr - BASE_ADDR) >> 3, taken modulo nothing.
  - out-of-range if addr < BASE_ADDR or index >= DEPTH_WORDS.
  - misaligned if addr[2:0] is not a multiple of (1 << size).
- Read:
  - dresp.data = full 64-bit word at the index, registered and valid only while data_ok=1. Byte extraction is the core's job.
  - dresp.data = 0 at all other times.
  - rd_count increments in the data_ok cycle.
- Write:
  - In the data_ok cycle, for each set strobe bit i, byte i of the word is replaced by data[8i+7:8i]; unset bytes are unchanged.
  - dresp.data = 0. wr_count increments.
- Bad access (out-of-range or misaligned):
  - data_ok is still returned with normal latency, so the core never deadlocks.
  - Reads return 0; writes are dropped.
  - err is set and stays 1 until reset.
  - The counters still increment.
- Read-after-write: a read accepted after a write's data_ok cycle returns the updated data.
- Counters wrap from 32'hFFFF_FFFF to 0.
- Reset asserted during WAIT or RESP: the pending operation is aborted. A pending write is not committed and the counters clear.
- dreq.valid dropped while in WAIT (protocol violation): the operation still completes from the latched copy.

Test Plan:
- Reset check: reset=0 then release, no requests -> addr_ok=0, data_ok=0, data=0, rd_count=0, wr_count=0, err=0 for 20 cycles.
- Write/read back with LATENCY=2:
  - write addr 0x8000_0010, data 0x1122334455667788, strobe 0xFF, size 3 -> addr_ok in cycle 0, data_ok in cycle 2, wr_count=1.
  - then read 0x8000_0010 -> data_ok in cycle 2 with data 0x1122334455667788, rd_count=1.
- Byte strobe: after the write above, write addr 0x8000_0013, size 0, strobe 0x08, data 0x0000_0000_AB00_0000; read 0x8000_0010 -> 0x11223344AB667788.
- Bad access:
  - read 0x7FFF_FFF8 -> data_ok after LATENCY, data 0, err=1.
  - write addr 0x8000_0011, size 2 -> RAM unchanged, err stays 1.
- Latency sweep: LATENCY=1 and LATENCY=15, three back-to-back reads -> data_ok exactly LATENCY cycles after each accept; accepts spaced LATENCY+1 cycles apart.
- Reset mid-operation: issue write 0x8000_0020 / 0xDEAD, assert reset during WAIT, release, read 0x8000_0020 -> old contents returned, wr_count=0, rd_count=1.
